// File: rtl/demux_1x6_buf_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared constants and helpers for the 1-to-6 buffered nibble demultiplexer.
//   Imported by the bus interface, the top level and the bench.
//
//   Contents:
//     WIDTH    data width of one word / one lane
//     LANES    number of output lanes (select codes 0..LANES-1 are legal)
//     SEL_W    width of the lane select
//     CNT_W    width of the saturating drop counter
//     SEL_MAX  highest legal select code
//     sel_legal()  1 when a select code addresses a real lane
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int WIDTH = 4;
  localparam int LANES = 6;
  localparam int SEL_W = 3;
  localparam int CNT_W = 8;

  localparam logic [SEL_W-1:0] SEL_MAX = 3'b101;

  // Codes above SEL_MAX (6 and 7) have no lane behind them.
  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return (sel <= SEL_MAX);
  endfunction

endpackage : demux_pkg

// File: rtl/demux_1x6_buf_if.sv
// -----------------------------------------------------------------------------
// demux_1x6_buf_if
//   Bundles the upstream word handshake, the six lane handshakes and the
//   illegal-select status into one bus.
//
//   Signals:
//     D_in       [WIDTH]        upstream data word
//     D_valid                   upstream word / select valid
//     D_select   [SEL_W]        destination lane
//     D_ready                   demux accepts the word this cycle
//     Y_out      [LANES*WIDTH]  lane i data at [i*WIDTH +: WIDTH]
//     Y_valid    [LANES]        lane i holds an unconsumed word
//     Y_ready    [LANES]        consumer i takes lane i this cycle
//     sel_err                   sticky illegal-select flag
//     drop_count [CNT_W]        saturating count of discarded words
//
//   Modports:
//     master  the environment: upstream producer plus the six consumers
//     slave   the demultiplexer itself
// -----------------------------------------------------------------------------
interface demux_1x6_buf_if;
  import demux_pkg::*;

  logic [WIDTH-1:0]       D_in;
  logic                   D_valid;
  logic [SEL_W-1:0]       D_select;
  logic                   D_ready;
  logic [LANES*WIDTH-1:0] Y_out;
  logic [LANES-1:0]       Y_valid;
  logic [LANES-1:0]       Y_ready;
  logic                   sel_err;
  logic [CNT_W-1:0]       drop_count;

  modport master (
    output D_in, D_valid, D_select, Y_ready,
    input  D_ready, Y_out, Y_valid, sel_err, drop_count
  );

  modport slave (
    input  D_in, D_valid, D_select, Y_ready,
    output D_ready, Y_out, Y_valid, sel_err, drop_count
  );

endinterface : demux_1x6_buf_if

// File: rtl/demux_1x6_buf_lane.sv
// -----------------------------------------------------------------------------
// demux_lane
//   One output lane of the demultiplexer: a single-entry holding register
//   with a valid bit. A push loads a new word; a pop frees the entry unless
//   a push lands in the same cycle, which gives one word per cycle per lane.
//
//   Ports:
//     clk         clock, rising edge
//     reset       synchronous, active-high
//     push        load push_data this cycle (already qualified by can_push)
//     push_data   [WIDTH] word to load
//     pop         consumer takes the held word this cycle
//     lane_data   [WIDTH] held word (keeps its value after a pop)
//     lane_valid  entry holds an unconsumed word
//     can_push    entry is free now or is being freed this cycle
// -----------------------------------------------------------------------------
module demux_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] lane_data,
  output logic             lane_valid,
  output logic             can_push
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A pop while empty is harmless: valid_q is already 0.
  assign can_push = !valid_q || pop;

  // NOTE: every variable written in an always_comb gets a default first so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (push) begin
      // Push wins over a same-cycle pop: the new word replaces the old one.
      data_d  = push_data;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the data register is reset as well as the valid bit, so the lane
  // output reads 0 after reset instead of whatever the flops powered up to.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign lane_data  = data_q;
  assign lane_valid = valid_q;

endmodule : demux_lane

// File: rtl/demux_1x6_buf.sv
// -----------------------------------------------------------------------------
// demux_1x6_buf
//   Routes one 4-bit word stream to one of six buffered output lanes chosen
//   by D_select. Each lane has its own one-entry register, so a stalled
//   consumer only blocks words addressed to its own lane. Words sent to an
//   illegal select (6, 7) are accepted and discarded, raising the sticky
//   sel_err flag and bumping a saturating drop counter.
//
//   Ports:
//     clk    clock, rising edge
//     reset  synchronous, active-high
//     bus    demux_1x6_buf_if.slave
//              in : D_in, D_valid, D_select, Y_ready
//              out: D_ready (combinational from D_select/Y_valid/Y_ready),
//                   Y_out, Y_valid, sel_err, drop_count
// -----------------------------------------------------------------------------
module demux_1x6_buf
  import demux_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  demux_1x6_buf_if.slave bus
);

  localparam int SEL_CODES = 2 ** SEL_W;

  logic [LANES-1:0]       push_vec;
  logic [LANES-1:0]       can_push;
  logic [LANES-1:0]       lane_valid;
  logic [WIDTH-1:0]       lane_data [LANES];
  logic [SEL_CODES-1:0]   can_push_ext;
  logic [LANES*WIDTH-1:0] y_out_flat;
  logic                   sel_ok;
  logic                   accept;

  logic                   sel_err_q, sel_err_d;
  logic [CNT_W-1:0]       drop_count_q, drop_count_d;

  // ---------------------------------------------------------------------------
  // Ready and accept
  // ---------------------------------------------------------------------------
  assign sel_ok = sel_legal(bus.D_select);

  // Illegal codes are padded with 1 so they always accept (and drop) the word.
  // D_valid deliberately does not feed D_ready.
  assign can_push_ext = {{(SEL_CODES - LANES){1'b1}}, can_push};
  assign bus.D_ready  = can_push_ext[bus.D_select];
  assign accept       = bus.D_valid && bus.D_ready;

  // One-hot push: at most one lane is written per cycle.
  always_comb begin
    push_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      push_vec[i] = accept && (bus.D_select == SEL_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Lanes
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .push       (push_vec[g]),
      .push_data  (bus.D_in),
      .pop        (bus.Y_ready[g]),
      .lane_data  (lane_data[g]),
      .lane_valid (lane_valid[g]),
      .can_push   (can_push[g])
    );
  end

  always_comb begin
    y_out_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      y_out_flat[i*WIDTH +: WIDTH] = lane_data[i];
    end
  end

  assign bus.Y_out   = y_out_flat;
  assign bus.Y_valid = lane_valid;

  // ---------------------------------------------------------------------------
  // Illegal-select bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_err_d    = sel_err_q;
    drop_count_d = drop_count_q;
    if (accept && !sel_ok) begin
      sel_err_d = 1'b1;
      // Saturate at all-ones rather than wrapping back to 0.
      if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      sel_err_q    <= sel_err_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.sel_err    = sel_err_q;
  assign bus.drop_count = drop_count_q;

endmodule : demux_1x6_buf

// File: doc/demux_1x6_buf.md
Name: demux_1x6_buf

Overview:
- Inverse of the team's 6-input 4-bit select mux: takes one 4-bit input stream and a 3-bit select, and routes each word to one of six output lanes.
- Each lane has a one-entry holding register with a valid/ready handshake, so a slow consumer stalls only its own lane.
- Sits between the shared nibble bus and the six per-channel consumers in the extra-problem datapath.

Parameters:
- WIDTH, 4, data width per word and per lane.
- LANES, 6, number of output lanes; select codes 0..LANES-1 are legal.
- SEL_W, 3, width of D_select.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- D_in  input  WIDTH  input data word.
- D_valid  input  1  D_in/D_select are valid this cycle.
- D_select  input  SEL_W  destination lane (3'b000..3'b101 legal).
- D_ready  output  1  block accepts the word this cycle (combinational).
- Y_out  output  LANES*WIDTH  lane i data at bits [i*WIDTH +: WIDTH].
- Y_valid  output  LANES  lane i holds an unconsumed word.
- Y_ready  input  LANES  consumer i takes the lane i word this cycle.
- sel_err  output  1  sticky flag: an illegal select was presented with D_valid.
- drop_count  output  CNT_W  saturating count of words dropped for illegal select.

Behaviour:
- Reset is synchronous, active-high; clock is clk. On reset, all of these clear to 0: Y_out, Y_valid, sel_err, drop_count. Reset takes priority over any same-cycle accept or pop.
- Accept condition: D_valid && D_ready.
- D_ready, legal select: D_ready = !Y_valid[D_select] || Y_ready[D_select].
- D_ready, illegal select (6, 7): D_ready = 1. The word is consumed and discarded.
- D_ready is combinational from D_select, Y_valid and Y_ready. There is no path from D_valid to D_ready.
- Legal accept: on the next edge, Y_out lane[D_select] <= D_in and Y_valid[D_select] <= 1. Latency is 1 cycle from accept to Y_valid.
- Pop: Y_valid[i] && Y_ready[i] clears Y_valid[i] on the next edge, unless the same lane accepts a word in the same cycle.
- Simultaneous pop and push on one lane: the new word is loaded and Y_valid stays 1. This gives full throughput of one word per cycle per lane.
- Pushes to lane k and pops on other lanes in the same cycle are independent.
- Y_out lane data holds its last value after a pop. Data is meaningful only while Y_valid = 1.
- Y_ready while Y_valid = 0 has no effect.
- Full lane (Y_valid = 1, Y_ready = 0) addressed: D_ready = 0, nothing changes, and the upstream must hold D_in and D_select.
- Illegal accept: sel_err <= 1 (sticky until reset). drop_count increments by 1 and saturates at 2^CNT_W-1 with no wrap.
- Only one lane is written per cycle; the block has no state machine beyond the per-lane valid bits.

Decomposition:
- Package demux_pkg:
  - constants LANES = 6, WIDTH = 4, SEL_W = 3;
  - localparam SEL_MAX = 3'b101;
  - function sel_legal(sel) returning sel <= SEL_MAX.
- Sub-module demux_lane, instantiated LANES times via generate. It holds one WIDTH-bit register and a valid bit, with ports:
  - push, push_data, pop;
  - lane_data, lane_valid, can_push (= !lane_valid || pop).
- The top level decodes D_select into a one-hot push vector, muxes can_push for D_ready, and owns sel_err and drop_count.

Test Plan:
- Reset: drive reset = 1 with D_valid = 1, D_select = 2, D_in = 4'hA for one edge -> Y_valid = 0, Y_out = 0, sel_err = 0, drop_count = 0 after the edge.
- Single route: D_in = 4'h5, D_select = 3'b011, D_valid = 1, all Y_ready = 0 -> next cycle Y_valid = 6'b001000 and lane3 = 4'h5. A second write to lane 3 sees D_ready = 0.
- Back-to-back: lane 0 with Y_ready[0] = 1 held, send 4'h1, 4'h2, 4'h3 on consecutive cycles -> D_ready stays 1. Lane0 shows 1, 2, 3 on consecutive cycles, with Y_valid[0] = 1 throughout.
- Fan-out: send one word to each lane 0..5 (values 4'h0..4'h5) with Y_ready = 0 -> Y_valid = 6'b111111 and each lane holds its index value. Then D_ready = 0 for every legal select.
- Illegal select: D_select = 3'b110, then 3'b111, with D_valid = 1 -> D_ready = 1, Y_valid unchanged, sel_err = 1, drop_count = 2. After 300 illegal accepts, drop_count = 255.
- Stall release: lane 4 full, Y_ready[4] = 0, upstream holding 4'hC to lane 4. Assert Y_ready[4] = 1 for one cycle -> D_ready = 1 in that cycle, and next cycle lane4 = 4'hC with Y_valid[4] = 1.
